// File: rtl/sample_window_buffer_pkg.sv
// Shared types and defaults for the sample window buffer and the difference engine it feeds.
// FRAME_LEN is one summation window plus the maximum lag.
package sample_window_buffer_pkg;

  localparam int DEFAULT_WINDOW_SIZE_BITS = 8;
  localparam int DEFAULT_DATA_WIDTH       = 16;
  localparam int DEFAULT_MAX_TAU          = 40;
  localparam int FRAME_COUNT_WIDTH        = 16;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  function automatic int frame_len(input int window_size_bits, input int max_tau);
    return (1 << window_size_bits) + max_tau;
  endfunction

  localparam int DEFAULT_FRAME_LEN = frame_len(DEFAULT_WINDOW_SIZE_BITS, DEFAULT_MAX_TAU);

endpackage

// File: rtl/sample_window_buffer_if.sv
// Sample stream in, frame array out. The master side is the sample producer and frame consumer;
// the slave side is the buffer itself.
interface sample_window_buffer_if
  import sample_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN
);

  logic [DATA_WIDTH-1:0]        sample_in;
  logic                         sample_valid;
  logic                         sample_ready;
  logic                         flush;
  logic                         frame_done;
  logic [DATA_WIDTH-1:0]        data_out [FRAME_LEN];
  logic                         frame_valid;
  logic                         frame_start;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count;

  modport master (
    output sample_in, sample_valid, flush, frame_done,
    input  sample_ready, data_out, frame_valid, frame_start, frame_count
  );

  modport slave (
    input  sample_in, sample_valid, flush, frame_done,
    output sample_ready, data_out, frame_valid, frame_start, frame_count
  );

endinterface

// File: rtl/sample_window_buffer.sv
// Sliding frame buffer: the first frame needs FRAME_LEN samples, each later one needs HOP_SIZE
// more. The frame is held stable until the consumer signals frame_done.
module sample_window_buffer
  import sample_window_buffer_pkg::*;
#(
  parameter int WINDOW_SIZE_BITS = DEFAULT_WINDOW_SIZE_BITS,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int MAX_TAU          = DEFAULT_MAX_TAU,
  parameter int HOP_SIZE         = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_window_buffer_if.slave bus
);

  localparam int FRAME_LEN = frame_len(WINDOW_SIZE_BITS, MAX_TAU);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FILL_TARGET = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] HOP_TARGET  = CNT_W'(HOP_SIZE);

  state_e                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         frame_valid_q;
  logic                         frame_start_q;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q;
  logic [DATA_WIDTH-1:0]        data_q [FRAME_LEN];

  logic             ready;
  logic             accept;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] target;

  assign ready  = (state_q != ST_HOLD);
  // A flushed cycle discards the sample even though ready is high.
  assign accept = bus.sample_valid && ready && !bus.flush;
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign target = (state_q == ST_FILL) ? FILL_TARGET : HOP_TARGET;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FILL;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else if (bus.flush) begin
      state_q       <= ST_FILL;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_start_q <= 1'b0;
      unique case (state_q)
        ST_FILL, ST_REFILL: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (cnt_d == target) begin
              state_q       <= ST_HOLD;
              frame_valid_q <= 1'b1;
              frame_start_q <= 1'b1;
              frame_count_q <= frame_count_q + FRAME_COUNT_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.frame_done) begin
            state_q       <= ST_REFILL;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_FILL;
          cnt_q         <= '0;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Index 0 holds the oldest sample; new samples enter at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        data_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        data_q[i] <= data_q[i+1];
      end
      data_q[FRAME_LEN-1] <= bus.sample_in;
    end
  end

  generate
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_out
      assign bus.data_out[gi] = data_q[gi];
    end
  endgenerate

  assign bus.sample_ready = ready;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_sample_window_buffer.sv
// Bench for sample_window_buffer: one instance with HOP_SIZE=128 and one with HOP_SIZE=1,
// each shadowed by a window model and checked every cycle, plus directed literal checks.
module tb_sample_window_buffer;
  import sample_window_buffer_pkg::*;

  localparam int DW    = 16;
  localparam int FL    = DEFAULT_FRAME_LEN;
  localparam int HOP_A = 128;
  localparam int HOP_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  sample_window_buffer_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) bus_a ();
  sample_window_buffer_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) bus_b ();

  sample_window_buffer #(
    .WINDOW_SIZE_BITS(8), .DATA_WIDTH(DW), .MAX_TAU(40), .HOP_SIZE(HOP_A)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );

  sample_window_buffer #(
    .WINDOW_SIZE_BITS(8), .DATA_WIDTH(DW), .MAX_TAU(40), .HOP_SIZE(HOP_B)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: last FL accepted samples, plus "holding a frame" and samples still owed.
  logic [DW-1:0] m_win [2][FL];
  bit            m_hold  [2];
  bit            m_first [2];
  bit            m_live  [2];
  int            m_got   [2];
  int            m_need  [2];
  int            m_frames[2];

  task automatic model_step(input int d, input logic rst, input logic vld,
                            input logic [DW-1:0] din, input logic fl,
                            input logic done, input int hop);
    if (rst) begin
      for (int i = 0; i < FL; i++) m_win[d][i] = '0;
      m_hold[d] = 0; m_first[d] = 0; m_got[d] = 0; m_need[d] = FL; m_frames[d] = 0;
      m_live[d] = 1;
    end else if (fl) begin
      m_hold[d] = 0; m_first[d] = 0; m_got[d] = 0; m_need[d] = FL; m_frames[d] = 0;
    end else if (m_hold[d]) begin
      m_first[d] = 0;
      if (done) begin
        m_hold[d] = 0; m_got[d] = 0; m_need[d] = hop;
      end
    end else begin
      m_first[d] = 0;
      if (vld) begin
        for (int i = 0; i < FL - 1; i++) m_win[d][i] = m_win[d][i+1];
        m_win[d][FL-1] = din;
        m_got[d]++;
        if (m_got[d] == m_need[d]) begin
          m_hold[d] = 1; m_first[d] = 1; m_frames[d] = (m_frames[d] + 1) & 16'hFFFF;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, bus_a.sample_valid, bus_a.sample_in, bus_a.flush, bus_a.frame_done, HOP_A);
    model_step(1, rst_b, bus_b.sample_valid, bus_b.sample_in, bus_b.flush, bus_b.frame_done, HOP_B);
  end

  task automatic cmp(input string tag, input int d, input logic rdy, input logic fv,
                     input logic fs, input logic [15:0] fc, input int bad);
    check({tag, ".sample_ready"}, rdy, !m_hold[d]);
    check({tag, ".frame_valid"},  fv,  m_hold[d]);
    check({tag, ".frame_start"},  fs,  m_first[d]);
    check({tag, ".frame_count"},  fc,  m_frames[d]);
    check({tag, ".data_out_bad_entries"}, bad, 0);
  endtask

  int bad_a;
  int bad_b;
  always @(negedge clk) begin
    if (m_live[0]) begin
      bad_a = 0;
      for (int i = 0; i < FL; i++) if (bus_a.data_out[i] !== m_win[0][i]) bad_a++;
      cmp("a", 0, bus_a.sample_ready, bus_a.frame_valid, bus_a.frame_start, bus_a.frame_count, bad_a);
    end
    if (m_live[1]) begin
      bad_b = 0;
      for (int i = 0; i < FL; i++) if (bus_b.data_out[i] !== m_win[1][i]) bad_b++;
      cmp("b", 1, bus_b.sample_ready, bus_b.frame_valid, bus_b.frame_start, bus_b.frame_count, bad_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents n consecutive samples; returns just after the edge that accepts the last one.
  task automatic feed_a(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus_a.sample_valid = 1'b1;
      bus_a.sample_in    = DW'(first + i);
    end
    tick();
    bus_a.sample_valid = 1'b0;
  endtask

  task automatic feed_b(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus_b.sample_valid = 1'b1;
      bus_b.sample_in    = DW'(first + i);
    end
    tick();
    bus_b.sample_valid = 1'b0;
  endtask

  function automatic int nonzero_a();
    int n = 0;
    for (int i = 0; i < FL; i++) if (bus_a.data_out[i] !== '0) n++;
    return n;
  endfunction

  function automatic int ramp_bad_a();
    int n = 0;
    for (int k = 0; k < FL; k++) if (bus_a.data_out[k] !== DW'(k)) n++;
    return n;
  endfunction

  int            acc_b;
  int            starts_b;
  logic [DW-1:0] last_b;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.sample_in = '0; bus_a.sample_valid = 1'b0; bus_a.flush = 1'b0; bus_a.frame_done = 1'b0;
    bus_b.sample_in = '0; bus_b.sample_valid = 1'b0; bus_b.flush = 1'b0; bus_b.frame_done = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0;
    check("reset.ready", bus_a.sample_ready, 1);
    check("reset.frame_valid", bus_a.frame_valid, 0);
    check("reset.frame_start", bus_a.frame_start, 0);
    check("reset.frame_count", bus_a.frame_count, 0);
    check("reset.data_nonzero", nonzero_a(), 0);

    // First frame from samples 0..295.
    feed_a(0, FL);
    check("fill.frame_start", bus_a.frame_start, 1);
    check("fill.frame_count", bus_a.frame_count, 1);
    check("fill.ramp_bad", ramp_bad_a(), 0);

    // Hold: offered samples must not enter.
    for (int c = 0; c < 50; c++) begin
      tick();
      bus_a.sample_valid = 1'b1;
      bus_a.sample_in    = DW'(999);
      if (c == 0) check("hold.ready", bus_a.sample_ready, 0);
    end
    tick();
    bus_a.sample_valid = 1'b0;
    check("hold.ramp_bad", ramp_bad_a(), 0);
    check("hold.frame_valid", bus_a.frame_valid, 1);
    check("hold.frame_start", bus_a.frame_start, 0);

    // Hop of 128 samples.
    bus_a.frame_done = 1'b1;
    tick();
    bus_a.frame_done = 1'b0;
    check("refill.frame_valid", bus_a.frame_valid, 0);
    feed_a(296, HOP_A);
    check("hop.frame_start", bus_a.frame_start, 1);
    check("hop.oldest", bus_a.data_out[0], 128);
    check("hop.newest", bus_a.data_out[FL-1], 423);
    check("hop.frame_count", bus_a.frame_count, 2);

    // Flush beats frame_done and a same-cycle sample.
    bus_a.flush = 1'b1; bus_a.frame_done = 1'b1;
    bus_a.sample_valid = 1'b1; bus_a.sample_in = DW'(7777);
    tick();
    bus_a.flush = 1'b0; bus_a.frame_done = 1'b0; bus_a.sample_valid = 1'b0;
    check("flush.frame_valid", bus_a.frame_valid, 0);
    check("flush.frame_count", bus_a.frame_count, 0);
    check("flush.ready", bus_a.sample_ready, 1);
    check("flush.sample_dropped", bus_a.data_out[FL-1], 423);
    feed_a(1000, FL - 1);
    check("flush.no_early_frame", bus_a.frame_valid, 0);
    feed_a(1000 + FL - 1, 1);
    check("flush.frame_start", bus_a.frame_start, 1);
    check("flush.frame_count", bus_a.frame_count, 1);
    check("flush.oldest", bus_a.data_out[0], 1000);
    check("flush.newest", bus_a.data_out[FL-1], 1295);

    // Reset 100 samples into a refill.
    bus_a.frame_done = 1'b1;
    tick();
    bus_a.frame_done = 1'b0;
    feed_a(2000, 100);
    check("abort.frame_valid", bus_a.frame_valid, 0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("abort.data_nonzero", nonzero_a(), 0);
    check("abort.frame_valid", bus_a.frame_valid, 0);
    check("abort.frame_count", bus_a.frame_count, 0);
    check("abort.ready", bus_a.sample_ready, 1);
    feed_a(3000, FL - 1);
    check("abort.no_early_frame", bus_a.frame_valid, 0);
    feed_a(3000 + FL - 1, 1);
    check("abort.frame_start", bus_a.frame_start, 1);
    check("abort.frame_count", bus_a.frame_count, 1);

    // HOP_SIZE=1 with 50% valid duty; consumer releases each frame immediately.
    rst_b = 1'b0;
    feed_b(0, FL);
    check("hop1.first_frame_start", bus_b.frame_start, 1);
    check("hop1.first_newest", bus_b.data_out[FL-1], 295);
    acc_b = 0; starts_b = 0; last_b = DW'(295);
    for (int c = 0; c < 200; c++) begin
      if (bus_b.frame_start === 1'b1) starts_b++;
      bus_b.frame_done   = m_hold[1];
      bus_b.sample_valid = 1'($urandom_range(0, 1));
      bus_b.sample_in    = DW'(5000 + acc_b);
      if (bus_b.sample_valid && !m_hold[1]) begin
        acc_b++;
        last_b = bus_b.sample_in;
      end
      tick();
    end
    bus_b.sample_valid = 1'b0;
    bus_b.frame_done   = 1'b0;
    if (bus_b.frame_start === 1'b1) starts_b++;
    check("hop1.frame_starts", starts_b, 1 + acc_b);
    check("hop1.frame_count", bus_b.frame_count, 1 + acc_b);
    check("hop1.newest", bus_b.data_out[FL-1], last_b);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_window_buffer.md
SAMPLE_WINDOW_BUFFER -- requirements
Module: sample_window_buffer

Interface
REQ-001 SHALL have parameter WINDOW_SIZE_BITS, default 8, meaning log2 of the summation window.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning sample width in bits, unsigned.
REQ-003 SHALL have parameter MAX_TAU, default 40, meaning maximum lag in samples (20 ms).
REQ-004 SHALL have parameter HOP_SIZE, default 128, meaning new samples between frames; legal range 1..FRAME_LEN.
REQ-005 SHALL define FRAME_LEN = 2**WINDOW_SIZE_BITS + MAX_TAU (296 at defaults).
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sample_in  input  DATA_WIDTH  incoming audio sample.
REQ-009 sample_valid  input  1  sample_in is valid this cycle.
REQ-010 sample_ready  output  1  buffer accepts sample_in this cycle.
REQ-011 flush  input  1  discard buffer contents and restart the initial fill.
REQ-012 frame_done  input  1  consumer has finished with the current frame.
REQ-013 data_out  output  DATA_WIDTH x FRAME_LEN  unpacked frame array; index 0 = oldest sample.
REQ-014 frame_valid  output  1  data_out holds a complete, stable frame.
REQ-015 frame_start  output  1  one-cycle pulse when a new frame becomes valid; drives difference-engine reset.
REQ-016 frame_count  output  16  number of frames issued since reset/flush, wraps at 2**16.

Function
REQ-017 SHALL implement states FILL, HOLD, REFILL with a sample counter of width $clog2(FRAME_LEN+1).
REQ-018 A sample SHALL be accepted iff sample_valid && sample_ready in the same cycle.
REQ-019 On acceptance, data_out SHALL shift down one place (data_out[i] <= data_out[i+1]), data_out[FRAME_LEN-1] <= sample_in, visible the next cycle.
REQ-020 sample_ready SHALL be 1 in FILL and REFILL, 0 in HOLD; combinational from state only.
REQ-021 FILL: counter increments per accepted sample; on the acceptance bringing it to FRAME_LEN, next state HOLD.
REQ-022 REFILL: counter increments per accepted sample; on the acceptance bringing it to HOP_SIZE, next state HOLD.
REQ-023 HOLD: data_out SHALL NOT change; frame_valid = 1; on frame_done, next state REFILL with counter cleared.
REQ-024 frame_start SHALL pulse high for exactly the first HOLD cycle; frame_count increments in that same cycle.
REQ-025 frame_valid SHALL be 0 in FILL and REFILL.
REQ-026 frame_done outside HOLD SHALL be ignored.
REQ-027 frame_done in the first HOLD cycle SHALL be honoured (HOLD lasts minimum one cycle).
REQ-028 flush SHALL, next cycle, force FILL, counter 0, frame_count 0, frame_valid 0; data_out contents need not be cleared.
REQ-029 flush SHALL take priority over frame_done and over a same-cycle sample acceptance (sample discarded).
REQ-030 HOP_SIZE = FRAME_LEN SHALL yield non-overlapping frames; HOP_SIZE = 1 SHALL yield one new sample per frame.
REQ-031 frame_count SHALL wrap 16'hFFFF -> 0 without affecting other behaviour.

Reset
REQ-032 reset SHALL, synchronously and with priority over all inputs, set state FILL, counter 0, frame_count 0, frame_valid 0, frame_start 0, and every data_out entry 0.
REQ-033 sample_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-034 reset during HOLD or REFILL SHALL abort the frame; no frame_start is issued until a full FRAME_LEN refill completes.

Structure
REQ-035 State encoding and FRAME_LEN computation SHALL live in a shared package together with DATA_WIDTH/WINDOW_SIZE_BITS/MAX_TAU defaults used by the difference engine.
REQ-036 SHALL be a single module; no sub-module; the state register, counter and shift array are all internal.
REQ-037 data_out SHALL be directly connectable to the difference engine's data_in, and frame_start to its reset.

Verification
REQ-038 Reset, then feed samples 0..295 with sample_valid held high -> frame_start pulse one cycle after sample 295 is accepted, data_out[k] = k, frame_count = 1.
REQ-039 In HOLD, hold sample_valid high with sample_in = 999 for 50 cycles -> sample_ready = 0, data_out unchanged, no acceptance.
REQ-040 Pulse frame_done, feed samples 296..423 -> second frame_start, data_out[0] = 128, data_out[295] = 423, frame_count = 2.
REQ-041 Assert flush and frame_done in the same HOLD cycle -> state FILL, frame_valid 0, frame_count 0; next frame only after 296 more samples.
REQ-042 Assert reset while 100 samples into REFILL -> all data_out 0, frame_valid 0; 296 samples needed for next frame_start.
REQ-043 Random sample_valid gaps (50% duty) with HOP_SIZE = 1 -> a frame after every accepted sample, data_out[295] = latest sample, frame_start exactly once per frame.
